// File: rtl/axi_mem_pkg.sv
// Shared constants and state types for the AXI memory responder.
package axi_mem_pkg;

    // Default AXI widths used by the responder
    localparam int unsigned AXI_ID_W   = 16;
    localparam int unsigned AXI_ADDR_W = 64;
    localparam int unsigned AXI_DATA_W = 512;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RdIdle,
        RdFetch,
        RdSend
    } rd_state_t;

    typedef enum logic [1:0] {
        WrIdle,
        WrData,
        WrResp
    } wr_state_t;

    // AxSIZE encoding of a full-width beat for a given data bus width
    function automatic logic [2:0] axi_full_size(input int unsigned data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Byte-writable DEPTH x DATA_W storage with one write port and one registered read port.
// Contents are not reset.
module axi_mem_array #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_idx,
    input  logic [DATA_W/8-1:0]        i_wr_be,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_rd_en,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
    output logic [DATA_W-1:0]          o_rd_data
);

    localparam int unsigned BYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Byte-enabled write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; a same-cycle write to the same word returns the old data
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: independent single-outstanding read and write engines
// serving INCR bursts from a private byte-writable array.
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int unsigned ID_W   = AXI_ID_W,
    parameter int unsigned ADDR_W = AXI_ADDR_W,
    parameter int unsigned DATA_W = AXI_DATA_W,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    // read address
    input  logic [ID_W-1:0]     arid_s,
    input  logic [ADDR_W-1:0]   araddr_s,
    input  logic [7:0]          arlen_s,
    input  logic [2:0]          arsize_s,
    input  logic                arvalid_s,
    output logic                arready_s,
    // read data
    output logic [ID_W-1:0]     rid_s,
    output logic [DATA_W-1:0]   rdata_s,
    output logic [1:0]          rresp_s,
    output logic                rlast_s,
    output logic                rvalid_s,
    input  logic                rready_s,
    // write address
    input  logic [ID_W-1:0]     awid_s,
    input  logic [ADDR_W-1:0]   awaddr_s,
    input  logic [7:0]          awlen_s,
    input  logic [2:0]          awsize_s,
    input  logic                awvalid_s,
    output logic                awready_s,
    // write data
    input  logic [DATA_W-1:0]   wdata_s,
    input  logic [DATA_W/8-1:0] wstrb_s,
    input  logic                wlast_s,
    input  logic                wvalid_s,
    output logic                wready_s,
    // write response
    output logic [ID_W-1:0]     bid_s,
    output logic [1:0]          bresp_s,
    output logic                bvalid_s,
    input  logic                bready_s
);

    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned OFF_W     = $clog2(BYTES);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [2:0]  SIZE_FULL = axi_full_size(DATA_W);

    // ---------------------------------------------------------------- read engine
    rd_state_t          r_rd_state;
    rd_state_t          w_rd_state_next;
    logic [ID_W-1:0]    r_rid;
    logic [IDX_W-1:0]   r_ridx;      // next word to load into the read register
    logic [7:0]         r_rrem;      // beats remaining after the one being presented
    logic               r_rerr;
    logic               w_ar_hs;
    logic               w_r_hs;
    logic               w_rd_load;
    logic [DATA_W-1:0]  w_rd_data;

    assign w_ar_hs = arvalid_s && arready_s;
    assign w_r_hs  = rvalid_s && rready_s;

    // Read next-state and array load control
    always_comb begin
        w_rd_state_next = r_rd_state;
        w_rd_load       = 1'b0;
        unique case (r_rd_state)
            RdIdle: begin
                if (w_ar_hs) begin
                    w_rd_state_next = RdFetch;
                end
            end
            RdFetch: begin
                w_rd_load       = 1'b1;
                w_rd_state_next = RdSend;
            end
            RdSend: begin
                if (w_r_hs) begin
                    if (r_rrem == 8'd0) begin
                        w_rd_state_next = RdIdle;
                    end else begin
                        // Prefetch the next beat on the same edge for 1 beat/cycle
                        w_rd_load = 1'b1;
                    end
                end
            end
            default: w_rd_state_next = RdIdle;
        endcase
    end

    // Read state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RdIdle;
        end else begin
            r_rd_state <= w_rd_state_next;
        end
    end

    // Read burst bookkeeping: id, word index, remaining beats, size error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rid  <= '0;
            r_ridx <= '0;
            r_rrem <= '0;
            r_rerr <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_rid  <= arid_s;
                r_ridx <= araddr_s[OFF_W +: IDX_W];
                r_rrem <= arlen_s;
                r_rerr <= (arsize_s != SIZE_FULL);
            end
            if (w_rd_load) begin
                r_ridx <= r_ridx + IDX_W'(1);
            end
            if (w_r_hs && (r_rrem != 8'd0)) begin
                r_rrem <= r_rrem - 8'd1;
            end
        end
    end

    // All outputs are forced low while reset is held
    assign arready_s = !rst && (r_rd_state == RdIdle);
    assign rvalid_s  = !rst && (r_rd_state == RdSend);
    assign rid_s     = rvalid_s ? r_rid : '0;
    assign rdata_s   = rvalid_s ? w_rd_data : '0;
    assign rresp_s   = (rvalid_s && r_rerr) ? RESP_SLVERR : RESP_OKAY;
    assign rlast_s   = rvalid_s && (r_rrem == 8'd0);

    // --------------------------------------------------------------- write engine
    wr_state_t          r_wr_state;
    wr_state_t          w_wr_state_next;
    logic [ID_W-1:0]    r_wid;
    logic [IDX_W-1:0]   r_widx;
    logic [7:0]         r_wcnt;      // beats remaining after the current one
    logic               r_werr_size;
    logic               r_werr_proto;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_b_hs;
    logic               w_wr_en;

    assign w_aw_hs = awvalid_s && awready_s;
    assign w_w_hs  = wvalid_s && wready_s;
    assign w_b_hs  = bvalid_s && bready_s;
    assign w_wr_en = w_w_hs && !r_werr_size;

    // Write next-state; the awlen beat count alone ends the data phase
    always_comb begin
        w_wr_state_next = r_wr_state;
        unique case (r_wr_state)
            WrIdle: begin
                if (w_aw_hs) begin
                    w_wr_state_next = WrData;
                end
            end
            WrData: begin
                if (w_w_hs && (r_wcnt == 8'd0)) begin
                    w_wr_state_next = WrResp;
                end
            end
            WrResp: begin
                if (w_b_hs) begin
                    w_wr_state_next = WrIdle;
                end
            end
            default: w_wr_state_next = WrIdle;
        endcase
    end

    // Write state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= WrIdle;
        end else begin
            r_wr_state <= w_wr_state_next;
        end
    end

    // Write burst bookkeeping: id, word index, beat count, sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wid        <= '0;
            r_widx       <= '0;
            r_wcnt       <= '0;
            r_werr_size  <= 1'b0;
            r_werr_proto <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_wid        <= awid_s;
                r_widx       <= awaddr_s[OFF_W +: IDX_W];
                r_wcnt       <= awlen_s;
                r_werr_size  <= (awsize_s != SIZE_FULL);
                r_werr_proto <= 1'b0;
            end
            if (w_w_hs) begin
                r_widx <= r_widx + IDX_W'(1);
                if (r_wcnt != 8'd0) begin
                    r_wcnt <= r_wcnt - 8'd1;
                end
                if (wlast_s != (r_wcnt == 8'd0)) begin
                    r_werr_proto <= 1'b1;
                end
            end
        end
    end

    assign awready_s = !rst && (r_wr_state == WrIdle);
    assign wready_s  = !rst && (r_wr_state == WrData);
    assign bvalid_s  = !rst && (r_wr_state == WrResp);
    assign bid_s     = bvalid_s ? r_wid : '0;
    assign bresp_s   = (bvalid_s && (r_werr_size || r_werr_proto)) ? RESP_SLVERR : RESP_OKAY;

    // Only the word-index bits of the addresses select storage
    logic w_unused_addr;
    assign w_unused_addr = ^{araddr_s, awaddr_s};

    // --------------------------------------------------------------------- storage
    axi_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .i_clk     (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_widx),
        .i_wr_be   (wstrb_s),
        .i_wr_data (wdata_s),
        .i_rd_en   (w_rd_load),
        .i_rd_idx  (r_ridx),
        .o_rd_data (w_rd_data)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed, table-driven bench for axi_mem_responder with a small memory model.
module tb_axi_mem_responder;

    localparam int ID_W   = 16;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int DEPTH  = 1024;
    localparam int BYTES  = DATA_W / 8;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLV  = 2'b10;

    logic                clk;
    logic                rst;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [BYTES-1:0]    wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    axi_mem_responder #(
        .ID_W   (ID_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arid_s    (arid),
        .araddr_s  (araddr),
        .arlen_s   (arlen),
        .arsize_s  (arsize),
        .arvalid_s (arvalid),
        .arready_s (arready),
        .rid_s     (rid),
        .rdata_s   (rdata),
        .rresp_s   (rresp),
        .rlast_s   (rlast),
        .rvalid_s  (rvalid),
        .rready_s  (rready),
        .awid_s    (awid),
        .awaddr_s  (awaddr),
        .awlen_s   (awlen),
        .awsize_s  (awsize),
        .awvalid_s (awvalid),
        .awready_s (awready),
        .wdata_s   (wdata),
        .wstrb_s   (wstrb),
        .wlast_s   (wlast),
        .wvalid_s  (wvalid),
        .wready_s  (wready),
        .bid_s     (bid),
        .bresp_s   (bresp),
        .bvalid_s  (bvalid),
        .bready_s  (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] model [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          wr;
        logic [15:0] id;
        logic [63:0] addr;
        int          len;
        logic [2:0]  size;
        logic [31:0] seed;
        logic [63:0] strb;
        int          wlast_at;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Beat k of a burst: every 32-bit lane holds seed + (k+1)*0x11 + lane<<24
    function automatic logic [DATA_W-1:0] pat(input logic [31:0] seed, input int k);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) begin
            d[i*32 +: 32] = seed + 32'(k + 1) * 32'h11 + (32'(i) << 24);
        end
        return d;
    endfunction

    task automatic wait_ready(input string name, input bit is_ar);
        int t;
        t = 0;
        while (((is_ar && !arready) || (!is_ar && !awready)) && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, is_ar ? arready : awready, 1);
    endtask

    task automatic do_write(input logic [15:0] id, input logic [63:0] addr, input int len,
                            input logic [2:0] size, input logic [31:0] seed,
                            input logic [63:0] strb, input int wlast_at,
                            input logic [1:0] exp_resp);
        logic [9:0] idx;
        logic [9:0] wi;
        logic [DATA_W-1:0] d;
        idx = addr[6 +: 10];
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awvalid = 1'b1;
        wait_ready("awready", 1'b0);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        chk("awready_busy", awready, 0);
        for (int k = 0; k <= len; k++) begin
            d = pat(seed, k);
            wdata = d; wstrb = strb; wlast = (k == wlast_at); wvalid = 1'b1;
            chk("wready", wready, 1);
            chk("bvalid_early", bvalid, 0);
            @(posedge clk);
            #1;
            if (size == 3'd6) begin
                wi = idx + 10'(k);
                for (int b = 0; b < BYTES; b++) begin
                    if (strb[b]) model[wi][b*8 +: 8] = d[b*8 +: 8];
                end
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid", bvalid, 1);
        chk("bid", bid, id);
        chk("bresp", bresp, exp_resp);
        bready = 1'b1;
        @(posedge clk);
        #1;
        bready = 1'b0;
        chk("bvalid_done", bvalid, 0);
        chk("awready_again", awready, 1);
    endtask

    task automatic do_read(input logic [15:0] id, input logic [63:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] exp_resp,
                           input logic [31:0] rdy_mask);
        logic [9:0] idx;
        int beat;
        int cyc;
        idx = addr[6 +: 10];
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arvalid = 1'b1;
        wait_ready("arready", 1'b1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        chk("rvalid_n1", rvalid, 0);
        @(posedge clk);
        #1;
        chk("rvalid_n2", rvalid, 1);
        beat = 0;
        cyc = 0;
        while (beat <= len && cyc < 600) begin
            rready = rdy_mask[cyc % 32];
            chk("rvalid", rvalid, 1);
            chk("rdata", rdata, model[idx + 10'(beat)]);
            chk("rid", rid, id);
            chk("rresp", rresp, exp_resp);
            chk("rlast", rlast, (beat == len));
            if (rready) beat++;
            @(posedge clk);
            #1;
            cyc++;
        end
        rready = 1'b0;
        chk("rvalid_done", rvalid, 0);
        chk("arready_again", arready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 16'hBEEF, 64'h0,     3, 3'd6, 32'h0,    '1,    3, OKAY};
        vecs[1]  = '{1'b0, 16'h1234, 64'h0,     3, 3'd6, 32'h0,    '0,    0, OKAY};
        vecs[2]  = '{1'b1, 16'h0001, 64'h40,    0, 3'd6, 32'h9A,   64'h1, 0, OKAY};
        vecs[3]  = '{1'b0, 16'h0002, 64'h40,    0, 3'd6, 32'h0,    '0,    0, OKAY};
        vecs[4]  = '{1'b1, 16'h0003, 64'hFF80,  3, 3'd6, 32'h1000, '1,    3, OKAY};
        vecs[5]  = '{1'b0, 16'h0004, 64'h0,     0, 3'd6, 32'h0,    '0,    0, OKAY};
        vecs[6]  = '{1'b0, 16'h0005, 64'h40,    0, 3'd6, 32'h0,    '0,    0, OKAY};
        vecs[7]  = '{1'b0, 16'h0006, 64'hFF80,  3, 3'd6, 32'h0,    '0,    0, OKAY};
        vecs[8]  = '{1'b0, 16'h0007, 64'h0,     1, 3'd3, 32'h0,    '0,    0, SLV};
        vecs[9]  = '{1'b1, 16'h0008, 64'h80,    1, 3'd3, 32'h2000, '1,    1, SLV};
        vecs[10] = '{1'b0, 16'h0009, 64'h80,    1, 3'd6, 32'h0,    '0,    0, OKAY};
        vecs[11] = '{1'b1, 16'h000A, 64'hC0,    3, 3'd6, 32'h3000, '1,    1, SLV};
        vecs[12] = '{1'b0, 16'h000B, 64'hC0,    3, 3'd6, 32'h0,    '0,    0, OKAY};
        vecs[13] = '{1'b0, 16'h000C, 64'h10000, 0, 3'd6, 32'h0,    '0,    0, OKAY};
        vecs[14] = '{1'b0, 16'h000D, 64'h45,    0, 3'd6, 32'h0,    '0,    0, OKAY};

        rst = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_arready", arready, 1);
        chk("post_rst_awready", awready, 1);

        for (int v = 0; v < 15; v++) begin
            if (vecs[v].wr) begin
                do_write(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].seed,
                         vecs[v].strb, vecs[v].wlast_at, vecs[v].resp);
            end else begin
                do_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].resp,
                        32'hFFFF_FFFF);
            end
        end

        // 8-beat burst read with rready 1-0-0-1 stalls
        do_write(16'h00AA, 64'h1000, 7, 3'd6, 32'h4000, '1, 7, OKAY);
        do_read(16'h1234, 64'h1000, 7, 3'd6, OKAY, 32'hFFFF_FFF9);

        // Reset after the second beat of a 4-beat read
        arid = 16'h0042; araddr = 64'h1000; arlen = 8'd3; arsize = 3'd6; arvalid = 1'b1;
        wait_ready("arready_rstseq", 1'b1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstseq_beat3_valid", rvalid, 1);
        rst = 1'b1;
        rready = 1'b0;
        @(posedge clk);
        #1;
        chk("rstseq_rvalid", rvalid, 0);
        chk("rstseq_arready", arready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstseq_arready_after", arready, 1);
        chk("rstseq_rvalid_after", rvalid, 0);
        do_read(16'h0043, 64'h1000, 1, 3'd6, OKAY, 32'hFFFF_FFFF);

        // 256-beat write, then spot-check first and last words
        do_write(16'h0077, 64'h200, 255, 3'd6, 32'h5000, '1, 255, OKAY);
        do_read(16'h0078, 64'h200, 0, 3'd6, OKAY, 32'hFFFF_FFFF);
        do_read(16'h0079, 64'(263 * 64), 0, 3'd6, OKAY, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
